// File: rtl/reg_apb_pkg.sv
// Shared types for the APB register slave front end.
// State encoding and index-width helper used by top and decoder.
package reg_apb_pkg;

  // Transfer sequencing: accept, strobe the register, respond.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STROBE = 2'd1,
    RESP   = 2'd2
  } state_e;

  // Index width for a register count; never narrower than one bit.
  function automatic int idx_width(input int n);
    if (n > 1) begin
      return $clog2(n);
    end
    return 1;
  endfunction

endpackage

// File: rtl/reg_apb_slave_if.sv
// APB bus bundle between a master and the register slave.
// Slave drives the response side, master the request side.
interface reg_apb_slave_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32
);

  logic                  psel;
  logic                  penable;
  logic                  pwrite;
  logic [ADDR_WIDTH-1:0] paddr;
  logic [DATA_WIDTH-1:0] pwdata;
  logic                  pready;
  logic [DATA_WIDTH-1:0] prdata;
  logic                  pslverr;

  modport master (
    output psel,
    output penable,
    output pwrite,
    output paddr,
    output pwdata,
    input  pready,
    input  prdata,
    input  pslverr
  );

  modport slave (
    input  psel,
    input  penable,
    input  pwrite,
    input  paddr,
    input  pwdata,
    output pready,
    output prdata,
    output pslverr
  );

endinterface

// File: rtl/reg_addr_decode.sv
// Byte address to register index decode.
// Flags a hit only for aligned, in-window addresses.
module reg_addr_decode #(
  parameter int                    ADDR_WIDTH = 12,
  parameter int                    REG_CNT    = 8,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  parameter int                    IDX_WIDTH  = 3
) (
  input  logic [ADDR_WIDTH-1:0] paddr_i,
  output logic                  hit_o,
  output logic [IDX_WIDTH-1:0]  idx_o
);

  logic [ADDR_WIDTH-1:0] off;
  logic [ADDR_WIDTH-1:0] word;
  logic                  above;
  logic                  aligned;
  logic                  in_rng;

  // Offset from base, word index, and the three hit conditions.
  always_comb begin
    off     = paddr_i - BASE_ADDR;
    word    = off >> 2;
    above   = (paddr_i >= BASE_ADDR);
    aligned = (off[1:0] == 2'b00);
    in_rng  = (word < ADDR_WIDTH'(REG_CNT));
    hit_o   = above & aligned & in_rng;
    idx_o   = IDX_WIDTH'(word);
  end

endmodule

// File: rtl/reg_apb_slave.sv
// APB slave front end producing per-register write/read strobes.
// Two wait states on hits let read-to-clear fields be sampled first.
module reg_apb_slave
  import reg_apb_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 12,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    REG_CNT    = 8,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
  input  logic                          clk,
  input  logic                          sync_rst,
  reg_apb_slave_if.slave                apb,
  output logic [REG_CNT-1:0]            sw_wr,
  output logic [REG_CNT-1:0]            sw_rd,
  output logic [DATA_WIDTH-1:0]         sw_wr_data,
  input  logic [REG_CNT*DATA_WIDTH-1:0] reg_rd_data
);

  localparam int IDX_WIDTH = idx_width(REG_CNT);

  state_e                state_q;
  state_e                state_d;
  logic                  wr_q;
  logic                  wr_d;
  logic [IDX_WIDTH-1:0]  idx_q;
  logic [IDX_WIDTH-1:0]  idx_d;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] wdata_d;
  logic [REG_CNT-1:0]    sw_wr_q;
  logic [REG_CNT-1:0]    sw_wr_d;
  logic [REG_CNT-1:0]    sw_rd_q;
  logic [REG_CNT-1:0]    sw_rd_d;
  logic                  pready_q;
  logic                  pready_d;
  logic                  pslverr_q;
  logic                  pslverr_d;
  logic [DATA_WIDTH-1:0] prdata_q;
  logic [DATA_WIDTH-1:0] prdata_d;

  logic                  dec_hit;
  logic [IDX_WIDTH-1:0]  dec_idx;
  logic [REG_CNT-1:0]    dec_hot;
  logic                  access;
  logic [DATA_WIDTH-1:0] rd_slice;

  reg_addr_decode #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .REG_CNT    (REG_CNT),
    .BASE_ADDR  (BASE_ADDR),
    .IDX_WIDTH  (IDX_WIDTH)
  ) u_dec (
    .paddr_i (apb.paddr),
    .hit_o   (dec_hit),
    .idx_o   (dec_idx)
  );

  // Access-phase detect, one-hot of the decoded index, selected read value.
  always_comb begin
    access   = apb.psel & apb.penable;
    dec_hot  = REG_CNT'(1) << dec_idx;
    rd_slice = reg_rd_data[idx_q*DATA_WIDTH +: DATA_WIDTH];
  end

  // Next-state and registered-output computation for the transfer FSM.
  always_comb begin
    state_d   = state_q;
    wr_d      = wr_q;
    idx_d     = idx_q;
    wdata_d   = wdata_q;
    sw_wr_d   = '0;
    sw_rd_d   = '0;
    pready_d  = 1'b0;
    pslverr_d = 1'b0;
    prdata_d  = prdata_q;
    case (state_q)
      IDLE: begin
        prdata_d = '0;
        if (access) begin
          wr_d    = apb.pwrite;
          idx_d   = dec_idx;
          wdata_d = apb.pwdata;
          if (dec_hit) begin
            state_d = STROBE;
            sw_wr_d = apb.pwrite ? dec_hot : '0;
            sw_rd_d = apb.pwrite ? '0 : dec_hot;
          end else begin
            state_d   = RESP;
            pready_d  = 1'b1;
            pslverr_d = 1'b1;
          end
        end
      end
      STROBE: begin
        if (!apb.psel) begin
          state_d = IDLE;
        end else begin
          state_d  = RESP;
          pready_d = 1'b1;
        end
        // Capture at the strobe edge so a read-to-clear field
        // still presents its pre-clear value.
        prdata_d = wr_q ? '0 : rd_slice;
      end
      RESP: begin
        state_d  = IDLE;
        prdata_d = '0;
      end
      default: begin
        state_d  = IDLE;
        prdata_d = '0;
      end
    endcase
  end

  // State and output registers; reset drops any transfer in flight.
  always_ff @(posedge clk) begin
    if (sync_rst) begin
      state_q   <= IDLE;
      wr_q      <= 1'b0;
      idx_q     <= '0;
      wdata_q   <= '0;
      sw_wr_q   <= '0;
      sw_rd_q   <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
    end else begin
      state_q   <= state_d;
      wr_q      <= wr_d;
      idx_q     <= idx_d;
      wdata_q   <= wdata_d;
      sw_wr_q   <= sw_wr_d;
      sw_rd_q   <= sw_rd_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      prdata_q  <= prdata_d;
    end
  end

  // All outputs come straight from flops.
  always_comb begin
    sw_wr       = sw_wr_q;
    sw_rd       = sw_rd_q;
    sw_wr_data  = wdata_q;
    apb.pready  = pready_q;
    apb.pslverr = pslverr_q;
    apb.prdata  = prdata_q;
  end

endmodule

// File: doc/reg_apb_slave.md
Name: reg_apb_slave

Overview:
- APB slave front end that sits directly upstream of the register field instances.
- Decodes APB address phases into per-register one-cycle software write and read strobes, plus broadcast write data.
- Gathers per-register read values into prdata, inserting fixed wait states so read-to-clear fields are sampled before they change.
- Out-of-range accesses return an error and never strobe a register.

Parameters:
- ADDR_WIDTH, 12, APB address width in bits.
- DATA_WIDTH, 32, APB data width and register width in bits.
- REG_CNT, 8, number of word-aligned registers served.
- BASE_ADDR, 12'h000, byte address of register 0. Register i sits at BASE_ADDR + 4*i.

Ports:
- clk  in  1  clock; all logic rises on posedge clk.
- sync_rst  in  1  synchronous active-high reset.
- psel  in  1  APB select.
- penable  in  1  APB enable (access phase).
- pwrite  in  1  1 = write, 0 = read.
- paddr  in  ADDR_WIDTH  APB byte address.
- pwdata  in  DATA_WIDTH  APB write data.
- pready  out  1  transfer complete.
- prdata  out  DATA_WIDTH  read data; valid when pready=1 and pwrite=0.
- pslverr  out  1  error response; valid with pready.
- sw_wr  out  REG_CNT  one-hot, one-cycle write strobe per register.
- sw_rd  out  REG_CNT  one-hot, one-cycle read strobe per register (drives read-side effects).
- sw_wr_data  out  DATA_WIDTH  registered pwdata, broadcast to all registers.
- reg_rd_data  in  REG_CNT*DATA_WIDTH  concatenated current register values; register i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].

Behaviour:
- Reset (sync_rst=1 at a posedge):
  - state <= IDLE.
  - pready, pslverr, sw_wr, sw_rd all 0.
  - prdata and sw_wr_data reset to 0.
  - Reset has priority over everything else. A transfer in flight is dropped with no strobe and no response.
- State IDLE: pready=0.
  - On psel=1 and penable=1, latch pwrite, pwdata and the decode result.
  - Offset = paddr - BASE_ADDR.
  - Hit when paddr >= BASE_ADDR, offset[1:0]==0, and offset>>2 < REG_CNT.
  - Hit → STROBE. Miss → RESP with err=1.
- State STROBE: lasts exactly one cycle.
  - sw_wr[idx] = wr, or sw_rd[idx] = !wr.
  - All other strobe bits are 0; at most one strobe bit is high in any cycle.
  - sw_wr_data holds the latched pwdata.
  - On a read, at this same edge prdata <= reg_rd_data slice idx, i.e. the pre-clear value.
  - Next state RESP.
- State RESP: pready=1 for exactly one cycle.
  - pslverr = err.
  - prdata is 0 on a write or on an error.
  - Next state IDLE.
- Latency: pready rises 3 cycles after the first access-phase cycle (2 wait states). A miss returns in 2 cycles (1 wait state).
- Back-to-back transfers: a new setup phase may follow RESP immediately. IDLE accepts a new access phase on the cycle after RESP.
- psel deasserted while in STROBE or RESP (protocol violation): return to IDLE next cycle.
  - No strobe is issued if the block has not yet reached STROBE.
  - An already-issued strobe is not undone.
- psel=1 with penable=0: ignored; the block waits for the access phase.
- Misaligned address, below-base address, or index >= REG_CNT: pslverr=1, no sw_wr/sw_rd pulse.
- sw_wr_data is stable from the STROBE cycle until the next latch.

Decomposition:
- Shared package reg_apb_pkg:
  - state enum {IDLE, STROBE, RESP}, 2 bits.
  - localparam IDX_WIDTH = $clog2(REG_CNT) rule.
- One sub-module, reg_addr_decode (combinational): takes paddr and returns a hit flag and index.
- The FSM, read-data capture and strobe registers live in the top module.

Test Plan (REG_CNT=4, BASE_ADDR=12'h100, DATA_WIDTH=32):
- Write 0xDEADBEEF to 0x108 → sw_wr=4'b0100 for 1 cycle with sw_wr_data=0xDEADBEEF; pready 3 cycles after penable; pslverr=0.
- Read 0x10C with reg_rd_data slice 3=0x12345678, and the bench clears slice 3 on sw_rd[3] → sw_rd=4'b1000 for 1 cycle; prdata=0x12345678 with pready.
- Read 0x110 (index 4), and read 0x102 (misaligned) → no strobe; pready after 2 cycles with pslverr=1 and prdata=0.
- Two back-to-back writes, 0x100 then 0x104 → sw_wr pulses 4'b0001 then 4'b0010, never overlapping; two pready pulses.
- sync_rst asserted during STROBE of a write → next cycle sw_wr=0 and pready=0, state IDLE; the following transfer completes normally.
- psel dropped in RESP → block returns to IDLE; the next read of 0x100 returns the correct data.
